// File: rtl/isr_core.sv
// In-service register for an 8-level interrupt controller: ack edge sets ISR bits, AEOI or EOI commands clear them.
// Optional feature: define ISR_SPECIAL_MASK_EN to make non-specific EOI skip specially masked levels.
module isr_core (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode,
    input  logic [2:0] modes_of_end_of_interrupt,
    input  logic [7:0] interrupt_special_mask,
    input  logic [7:0] highest_priority_interrupt,
    input  logic       acknowledge,
    input  logic [7:0] end_of_interrupt,
    input  logic [3:0] specific_level_clear,
    output logic [7:0] in_service_register,
    output logic [7:0] last_serviced
);

    logic       ack_q;
    logic       first_edge_q;
    logic       ack_rise;
    logic       ack_fall;
    logic [7:0] eoi_candidates;
    logic [7:0] lowest_candidate;
    logic [7:0] specific_bit;
    logic [7:0] clear_bits;
    logic [7:0] set_bits;

    // The first edge after reset only samples acknowledge, so a level held
    // high across reset deassertion is never mistaken for a new acknowledge.
    assign ack_rise = acknowledge & ~ack_q & ~first_edge_q;
    assign ack_fall = ~acknowledge & ack_q & ~first_edge_q;

`ifdef ISR_SPECIAL_MASK_EN
    assign eoi_candidates = in_service_register & ~interrupt_special_mask;
`else
    logic unused_special_mask;
    assign unused_special_mask = ^interrupt_special_mask;
    assign eoi_candidates      = in_service_register;
`endif

    // Level 0 is highest priority, so the lowest set bit is the one to retire.
    assign lowest_candidate = eoi_candidates & (~eoi_candidates + 8'd1);
    assign specific_bit     = specific_level_clear[3] ? (8'd1 << specific_level_clear[2:0]) : 8'd0;

    always_comb begin
        clear_bits = 8'd0;
        if (mode) begin
            if (ack_fall)
                clear_bits = last_serviced;
        end else if (end_of_interrupt != 8'd0) begin
            case (modes_of_end_of_interrupt)
                3'b000:          clear_bits = end_of_interrupt;
                3'b001, 3'b101:  clear_bits = lowest_candidate;
                3'b011, 3'b111:  clear_bits = specific_bit;
                default:         clear_bits = 8'd0;
            endcase
        end
    end

    assign set_bits = ack_rise ? highest_priority_interrupt : 8'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q               <= 1'b0;
            first_edge_q        <= 1'b1;
            in_service_register <= 8'd0;
            last_serviced       <= 8'd0;
        end else begin
            ack_q        <= acknowledge;
            first_edge_q <= 1'b0;
            // Clears come from the current register; a same-edge set wins.
            in_service_register <= (in_service_register & ~clear_bits) | set_bits;
            if (ack_rise)
                last_serviced <= highest_priority_interrupt;
        end
    end

endmodule

// File: tb/tb_isr_core.sv
// Directed bench for isr_core: hand-computed ISR / last_serviced values after each edge.
module tb_isr_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mode;
    logic [2:0] modes_of_end_of_interrupt;
    logic [7:0] interrupt_special_mask;
    logic [7:0] highest_priority_interrupt;
    logic       acknowledge;
    logic [7:0] end_of_interrupt;
    logic [3:0] specific_level_clear;
    logic [7:0] in_service_register;
    logic [7:0] last_serviced;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    isr_core dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .mode                       (mode),
        .modes_of_end_of_interrupt  (modes_of_end_of_interrupt),
        .interrupt_special_mask     (interrupt_special_mask),
        .highest_priority_interrupt (highest_priority_interrupt),
        .acknowledge                (acknowledge),
        .end_of_interrupt           (end_of_interrupt),
        .specific_level_clear       (specific_level_clear),
        .in_service_register        (in_service_register),
        .last_serviced              (last_serviced)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // scoreboard: expected ISR then last_serviced are queued, then compared
    task automatic expect_out(input string tag, input logic [7:0] isr_exp, input logic [7:0] ls_exp);
        exp_q.push_back(isr_exp);
        exp_q.push_back(ls_exp);
        check({tag, ".isr"}, in_service_register, exp_q.pop_front());
        check({tag, ".ls"},  last_serviced,       exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: full acknowledge pulse (rise edge then fall edge)
    task automatic ack_pulse(input logic [7:0] hpi);
        highest_priority_interrupt = hpi;
        acknowledge = 1'b1;
        step();
        acknowledge = 1'b0;
        step();
    endtask

    task automatic eoi_cmd(input logic [2:0] code, input logic [7:0] eoi, input logic [3:0] slc);
        modes_of_end_of_interrupt = code;
        end_of_interrupt          = eoi;
        specific_level_clear      = slc;
        step();
        end_of_interrupt          = 8'd0;
        specific_level_clear      = 4'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        mode = 1'b0;
        modes_of_end_of_interrupt = 3'd0;
        interrupt_special_mask = 8'd0;
        highest_priority_interrupt = 8'd0;
        acknowledge = 1'b1;
        end_of_interrupt = 8'd0;
        specific_level_clear = 4'd0;

        // reset with acknowledge high, before any clock edge
        #2;
        expect_out("reset_no_clk", 8'h00, 8'h00);
        acknowledge = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();

        // AEOI
        mode = 1'b1;
        highest_priority_interrupt = 8'h20;
        acknowledge = 1'b1;
        step();
        expect_out("aeoi_rise", 8'h20, 8'h20);
        acknowledge = 1'b0;
        step();
        expect_out("aeoi_fall", 8'h00, 8'h20);

        // non-specific EOI
        mode = 1'b0;
        ack_pulse(8'h20);
        ack_pulse(8'h01);
        expect_out("nonspec_build", 8'h21, 8'h01);
        eoi_cmd(3'b001, 8'h01, 4'd0);
        expect_out("nonspec_1", 8'h20, 8'h01);
        step();
        expect_out("nonspec_idle", 8'h20, 8'h01);
        eoi_cmd(3'b101, 8'h01, 4'd0);
        expect_out("nonspec_2", 8'h00, 8'h01);
        eoi_cmd(3'b001, 8'h01, 4'd0);
        expect_out("nonspec_empty", 8'h00, 8'h01);

        // specific EOI
        ack_pulse(8'h20);
        ack_pulse(8'h01);
        eoi_cmd(3'b011, 8'h01, 4'b1101);
        expect_out("specific_lvl5", 8'h01, 8'h01);
        eoi_cmd(3'b011, 8'h01, 4'b0101);
        expect_out("specific_invalid", 8'h01, 8'h01);
        eoi_cmd(3'b111, 8'hFF, 4'b1000);
        expect_out("specific_lvl0", 8'h00, 8'h01);

        // vector clear and unused codes
        ack_pulse(8'h04);
        ack_pulse(8'h10);
        expect_out("vector_build", 8'h14, 8'h10);
        eoi_cmd(3'b000, 8'h04, 4'd0);
        expect_out("vector_clear", 8'h10, 8'h10);
        eoi_cmd(3'b010, 8'hFF, 4'b1100);
        expect_out("code_010_noop", 8'h10, 8'h10);
        eoi_cmd(3'b110, 8'hFF, 4'b1100);
        expect_out("code_110_noop", 8'h10, 8'h10);
        eoi_cmd(3'b000, 8'h10, 4'd0);
        expect_out("vector_clear2", 8'h00, 8'h10);

        // special mask on non-specific EOI
        ack_pulse(8'h01);
        ack_pulse(8'h02);
        interrupt_special_mask = 8'h01;
        eoi_cmd(3'b001, 8'h01, 4'd0);
`ifdef ISR_SPECIAL_MASK_EN
        expect_out("special_mask", 8'h01, 8'h02);
`else
        expect_out("special_mask", 8'h02, 8'h02);
`endif
        interrupt_special_mask = 8'h00;
        eoi_cmd(3'b000, 8'hFF, 4'd0);
        expect_out("clear_all", 8'h00, 8'h02);

        // same-edge set and clear of one bit
        ack_pulse(8'h04);
        highest_priority_interrupt = 8'h04;
        acknowledge = 1'b1;
        modes_of_end_of_interrupt = 3'b000;
        end_of_interrupt = 8'h04;
        step();
        end_of_interrupt = 8'h00;
        expect_out("collision", 8'h04, 8'h04);
        acknowledge = 1'b0;
        step();

        // acknowledge with no winner
        highest_priority_interrupt = 8'h00;
        acknowledge = 1'b1;
        step();
        expect_out("ack_no_hpi", 8'h04, 8'h00);
        acknowledge = 1'b0;
        step();

        // mode switch alone, then AEOI ignores EOI commands
        mode = 1'b1;
        step();
        expect_out("mode_switch", 8'h04, 8'h00);
        eoi_cmd(3'b000, 8'hFF, 4'd0);
        expect_out("aeoi_ignores_eoi", 8'h04, 8'h00);
        highest_priority_interrupt = 8'h04;
        acknowledge = 1'b1;
        step();
        expect_out("aeoi_rise2", 8'h04, 8'h04);
        acknowledge = 1'b0;
        step();
        expect_out("aeoi_fall2", 8'h00, 8'h04);

        // reset in the middle of an acknowledge, released with ack still high
        mode = 1'b0;
        highest_priority_interrupt = 8'h08;
        acknowledge = 1'b1;
        step();
        expect_out("pre_reset", 8'h08, 8'h08);
        #3;
        reset_n = 1'b0;
        #1;
        expect_out("async_reset", 8'h00, 8'h00);
        step();
        reset_n = 1'b1;
        step();
        expect_out("post_reset_edge1", 8'h00, 8'h00);
        step();
        expect_out("post_reset_edge2", 8'h00, 8'h00);
        acknowledge = 1'b0;
        step();
        acknowledge = 1'b1;
        step();
        expect_out("post_reset_reack", 8'h08, 8'h08);
        acknowledge = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
